// File: rtl/cnn_layer_seq.sv
// ---------------------------------------------------------------------------
// cnn_layer_seq
//   Hardware layer sequencer for the CNN accelerator. It walks a small
//   per-layer table. For each layer it presents the base addresses and the
//   layer-config word, pulses a start, and waits for the accelerator's
//   layer-done level. It then advances the weight/param base addresses by an
//   amount that depends on the layer type. A per-layer timeout aborts the
//   sequence with a sticky error flag.
//
// Ports
//   HCLK, HRESET    clock, synchronous active-high reset
//   i_tbl_we/idx/data  table write port {act[2:0], bias[4:0], is_conv3x3};
//                   ignored while busy or when idx >= N_LAYER
//   i_seq_start     start pulse (ignored while busy)
//   i_abort         abandon the running sequence
//   i_layer_done    accelerator layer-done level
//   o_base_addr     {param_base[11:0], weight_base[19:0]}
//   o_layer_config  {16'b0, act, bias, idx, last, conv3x3, last, first}
//   o_layer_start   one-cycle start pulse to the accelerator
//   o_layer_index   current layer
//   o_busy          sequence in progress
//   o_seq_done      one-cycle pulse when the last layer has completed
//   o_error         sticky timeout flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module cnn_layer_seq #(
    parameter int N_LAYER   = 3,
    parameter int Ti        = 16,
    parameter int To        = 16,
    parameter int N         = 16,
    parameter int W_TIMEOUT = 24
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        i_tbl_we,
    input  logic [3:0]  i_tbl_idx,
    input  logic [8:0]  i_tbl_data,
    input  logic        i_seq_start,
    input  logic        i_abort,
    input  logic        i_layer_done,
    output logic [31:0] o_base_addr,
    output logic [31:0] o_layer_config,
    output logic        o_layer_start,
    output logic [3:0]  o_layer_index,
    output logic        o_busy,
    output logic        o_seq_done,
    output logic        o_error
);

    localparam logic [19:0] W_INC_CONV = 20'(Ti * To * 9 / N);
    localparam logic [19:0] W_INC_1X1  = 20'(To);
    localparam logic [11:0] P_INC      = 12'(To);
    localparam logic [4:0]  NL         = 5'(N_LAYER);
    localparam logic [3:0]  LAST_IDX   = 4'(N_LAYER - 1);
    localparam logic [W_TIMEOUT-1:0] TCNT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT_CLR,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_n;

    // Layer table is sized for the full 4-bit index so it can be addressed
    // directly; only entries below N_LAYER are ever written or read.
    logic [8:0]           tbl [16];
    logic [3:0]           idx, nxt_idx;
    logic [19:0]          weight, nxt_weight;
    logic [11:0]          param, nxt_param;
    logic [W_TIMEOUT-1:0] tcnt;
    logic                 err;

    logic clr_seq, adv, set_err, run_tcnt, clr_tcnt, tmo, is_last;
    logic load_cfg, nxt_last;
    logic [8:0] ent;

    assign tmo           = (tcnt == '1);
    assign is_last       = (idx == LAST_IDX);
    assign o_layer_index = idx;
    assign o_error       = err;

    // ---------------- FSM ----------------
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n       = state;
        clr_seq       = 1'b0;
        adv           = 1'b0;
        set_err       = 1'b0;
        run_tcnt      = 1'b0;
        clr_tcnt      = 1'b0;
        o_layer_start = 1'b0;
        o_busy        = 1'b0;
        o_seq_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_seq_start) begin
                    state_n = S_SETUP;
                    clr_seq = 1'b1;
                end
            end
            S_SETUP: begin
                o_busy  = 1'b1;
                state_n = S_START;
            end
            S_START: begin
                o_busy        = 1'b1;
                o_layer_start = 1'b1;
                clr_tcnt      = 1'b1;
                state_n       = S_WAIT_CLR;
            end
            // done may still be high from the previous layer; wait for it
            // to drop before looking for this layer's rising level.
            S_WAIT_CLR: begin
                o_busy   = 1'b1;
                run_tcnt = 1'b1;
                if (tmo) begin
                    set_err = 1'b1;
                    state_n = S_IDLE;
                end else if (!i_layer_done) begin
                    state_n = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                o_busy   = 1'b1;
                run_tcnt = 1'b1;
                if (tmo) begin
                    set_err = 1'b1;
                    state_n = S_IDLE;
                end else if (i_layer_done) begin
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                o_busy  = 1'b1;
                adv     = 1'b1;
                state_n = is_last ? S_DONE : S_SETUP;
            end
            S_DONE: begin
                o_seq_done = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Abort beats timeout and done; it suppresses every pulse of this cycle.
        if (i_abort && state != S_IDLE) begin
            state_n       = S_IDLE;
            set_err       = 1'b0;
            adv           = 1'b0;
            o_layer_start = 1'b0;
            o_seq_done    = 1'b0;
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        nxt_idx    = idx;
        nxt_weight = weight;
        nxt_param  = param;
        if (clr_seq) begin
            nxt_idx    = '0;
            nxt_weight = '0;
            nxt_param  = '0;
        end else if (adv) begin
            // config bit 2 is the type of the layer that just finished
            nxt_weight = weight + (o_layer_config[2] ? W_INC_CONV : W_INC_1X1);
            nxt_param  = param + P_INC;
            if (!is_last) nxt_idx = idx + 4'd1;
        end
        // Config is captured on entry to SETUP so it is already stable
        // for the whole SETUP cycle ahead of the start pulse.
        load_cfg = (state_n == S_SETUP);
        ent      = tbl[nxt_idx];
        nxt_last = (nxt_idx == LAST_IDX);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            idx            <= '0;
            weight         <= '0;
            param          <= '0;
            tcnt           <= '0;
            err            <= 1'b0;
            o_base_addr    <= '0;
            o_layer_config <= '0;
        end else begin
            idx    <= nxt_idx;
            weight <= nxt_weight;
            param  <= nxt_param;

            if (clr_tcnt)              tcnt <= '0;
            else if (run_tcnt && !tmo) tcnt <= tcnt + TCNT_ONE;

            if (clr_seq)      err <= 1'b0;
            else if (set_err) err <= 1'b1;

            if (load_cfg) begin
                o_base_addr    <= {nxt_param, nxt_weight};
                o_layer_config <= {16'h0, ent[8:6], ent[5:1], nxt_idx,
                                   nxt_last, ent[0], nxt_last, (nxt_idx == 4'd0)};
            end
        end
    end

    // Table contents survive reset; writes are locked out during a sequence.
    always_ff @(posedge HCLK) begin
        if (i_tbl_we && !o_busy && ({1'b0, i_tbl_idx} < NL))
            tbl[i_tbl_idx] <= i_tbl_data;
    end

endmodule

// File: tb/tb_cnn_layer_seq.sv
module tb_cnn_layer_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we_a, we_b;
    logic [3:0]  tidx;
    logic [8:0]  tdata;
    logic        start_a, start_b, abort_a, abort_b, done_a, done_b;
    logic [31:0] base_a, cfg_a, base_b, cfg_b;
    logic        ls_a, ls_b, busy_a, busy_b, sd_a, sd_b, err_a, err_b;
    logic [3:0]  li_a, li_b;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  ref_a [16];
    logic [8:0]  ref_b [16];
    logic [31:0] rec_cfg  [16];
    logic [31:0] rec_base [16];

    logic [31:0] o_base, o_cfg;
    logic        o_ls, o_busy, o_sd, o_err;
    logic [3:0]  o_li;

    cnn_layer_seq #(.N_LAYER(3), .W_TIMEOUT(8)) dut_a (
        .HCLK(clk), .HRESET(rst), .i_tbl_we(we_a), .i_tbl_idx(tidx), .i_tbl_data(tdata),
        .i_seq_start(start_a), .i_abort(abort_a), .i_layer_done(done_a),
        .o_base_addr(base_a), .o_layer_config(cfg_a), .o_layer_start(ls_a),
        .o_layer_index(li_a), .o_busy(busy_a), .o_seq_done(sd_a), .o_error(err_a));

    cnn_layer_seq #(.N_LAYER(16), .W_TIMEOUT(8)) dut_b (
        .HCLK(clk), .HRESET(rst), .i_tbl_we(we_b), .i_tbl_idx(tidx), .i_tbl_data(tdata),
        .i_seq_start(start_b), .i_abort(abort_b), .i_layer_done(done_b),
        .o_base_addr(base_b), .o_layer_config(cfg_b), .o_layer_start(ls_b),
        .o_layer_index(li_b), .o_busy(busy_b), .o_seq_done(sd_b), .o_error(err_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            o_base = base_a; o_cfg = cfg_a; o_ls = ls_a; o_busy = busy_a;
            o_sd = sd_a; o_err = err_a; o_li = li_a;
        end else begin
            o_base = base_b; o_cfg = cfg_b; o_ls = ls_b; o_busy = busy_b;
            o_sd = sd_b; o_err = err_b; o_li = li_b;
        end
    endtask

    task automatic drv(input int sel, input logic st, input logic ab, input logic dn);
        if (sel == 0) begin start_a = st; abort_a = ab; done_a = dn; end
        else          begin start_b = st; abort_b = ab; done_b = dn; end
    endtask

    task automatic wr(input int sel, input int i, input logic [8:0] d);
        @(negedge clk);
        tidx = 4'(i); tdata = d;
        if (sel == 0) we_a = 1'b1; else we_b = 1'b1;
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;
        if (sel == 0 && i < 3) ref_a[i] = d;
        if (sel == 1)          ref_b[i] = d;
    endtask

    // Expected config word straight from the field layout of the table entry.
    function automatic logic [31:0] exp_cfg(input logic [8:0] e, input int i, input int nl);
        logic lst;
        lst = (i == nl - 1);
        return {16'h0, e[8:6], e[5:1], i[3:0], lst, e[0], lst, (i == 0)};
    endfunction

    // Runs one sequence with an accelerator model attached. After each start
    // pulse the model drops done after 'hold' cycles, then raises it after a
    // random delay. abort_off < 0 places the abort on the same cycle as done.
    task automatic run_seq(input int sel, input int nl, input int dmin, input int dmax,
                           input int hold, input int abort_layer, input int abort_off,
                           input bit poke, input int budget,
                           output int n_ls, output int n_sd, output int err_cyc);
        int w, p, drop_at, rise_at, last_rise, abort_at, end_at, k;
        logic [8:0]  e;
        logic [31:0] prev_cfg, exp_c, exp_b, last_c, last_b;
        logic dn, st, ab;
        w = 0; p = 0; n_ls = 0; n_sd = 0; err_cyc = -1;
        drop_at = -1; rise_at = -1; last_rise = -1; abort_at = -1; end_at = budget;
        last_c = 0; last_b = 0; prev_cfg = 0;
        dn = (sel == 0) ? done_a : done_b;
        @(negedge clk);
        drv(sel, 1'b1, 1'b0, dn);
        for (int cyc = 1; cyc <= end_at; cyc++) begin
            @(negedge clk);
            sample(sel);
            st = 1'b0; ab = 1'b0;
            if (cyc == 1) begin
                chk("busy_after_start", 32'(o_busy), 1);
                chk("err_cleared_by_start", 32'(o_err), 0);
            end
            if (o_ls) begin
                k = n_ls;
                n_ls++;
                if (k == 0) chk("start_to_first_start_latency", cyc, 2);
                else        chk("done_to_next_start_latency", cyc, last_rise + 3);
                e = (sel == 0) ? ref_a[k & 15] : ref_b[k & 15];
                exp_c = exp_cfg(e, k, nl);
                exp_b = 32'(p) * 32'h0010_0000 + 32'(w);
                chk("layer_config", o_cfg, exp_c);
                chk("config_stable_before_start", prev_cfg, exp_c);
                chk("base_addr", o_base, exp_b);
                chk("layer_index", 32'(o_li), k);
                if (k < 16) begin rec_cfg[k] = o_cfg; rec_base[k] = o_base; end
                last_c = exp_c; last_b = exp_b;
                w = (w + (e[0] ? 144 : 16)) % (1 << 20);
                p = (p + 16) % 4096;
                drop_at = cyc + hold;
                rise_at = drop_at + int'($urandom_range(dmax, dmin));
                if (k == abort_layer) abort_at = (abort_off < 0) ? rise_at : cyc + abort_off;
            end
            if (o_sd) begin
                n_sd++;
                chk("seq_done_latency", cyc, last_rise + 2);
                chk("busy_low_at_done", 32'(o_busy), 0);
                chk("config_held_after_done", o_cfg, last_c);
                chk("base_held_after_done", o_base, last_b);
                if (n_sd == 1) end_at = cyc + 3;
            end
            if (o_err && err_cyc < 0) begin
                err_cyc = cyc;
                chk("busy_low_at_timeout", 32'(o_busy), 0);
                end_at = cyc + 3;
            end
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                chk("busy_low_after_abort", 32'(o_busy), 0);
                end_at = cyc + 60;
            end
            if (cyc == drop_at) dn = 1'b0;
            if (cyc == rise_at) begin dn = 1'b1; last_rise = cyc; end
            if (cyc == abort_at) ab = 1'b1;
            if (poke && cyc == 10) begin
                // table write and start while busy: both must be ignored
                st = 1'b1;
                tidx = 4'(nl - 1);
                tdata = ~((sel == 0) ? ref_a[nl - 1] : ref_b[nl - 1]);
                if (sel == 0) we_a = 1'b1; else we_b = 1'b1;
            end else begin
                we_a = 1'b0; we_b = 1'b0;
            end
            drv(sel, st, ab, dn);
            prev_cfg = o_cfg;
        end
        drv(sel, 1'b0, 1'b0, dn);
    endtask

    initial begin
        int nls, nsd, ecyc, extra;
        rst = 1'b1; we_a = 0; we_b = 0; tidx = 0; tdata = 0;
        start_a = 0; start_b = 0; abort_a = 0; abort_b = 0; done_a = 0; done_b = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("reset_cfg_a", cfg_a, 0);
        chk("reset_base_a", base_a, 0);
        chk("reset_outputs_a", {25'b0, ls_a, busy_a, sd_a, err_a, li_a}, 0);
        chk("reset_outputs_b", {cfg_b | base_b} | {25'b0, ls_b, busy_b, sd_b, err_b, li_b}, 0);

        // T1: directed table, done 50 cycles after each start
        wr(0, 0, {3'd7, 5'd9, 1'b0});
        wr(0, 1, {3'd7, 5'd17, 1'b1});
        wr(0, 2, {3'd7, 5'd17, 1'b1});
        wr(0, 5, 9'h1FF);
        run_seq(0, 3, 50, 50, 0, -1, 0, 1'b0, 2000, nls, nsd, ecyc);
        chk("t1_starts", nls, 3);
        chk("t1_seq_done_count", nsd, 1);
        chk("t1_no_error", ecyc, -1);
        chk("t1_cfg0", rec_cfg[0], 32'h0000E901);
        chk("t1_cfg1", rec_cfg[1], 32'h0000F114);
        chk("t1_cfg2", rec_cfg[2], 32'h0000F12E);
        chk("t1_base0", rec_base[0], 32'h00000000);
        chk("t1_base1", rec_base[1], 32'h01000010);
        chk("t1_base2", rec_base[2], 32'h020000A0);

        // T2: done left high across start, must see a drop and a fresh rise
        done_a = 1'b1;
        run_seq(0, 3, 5, 30, 15, -1, 0, 1'b0, 2000, nls, nsd, ecyc);
        chk("t2_starts", nls, 3);
        chk("t2_seq_done_count", nsd, 1);

        // T5: writes and start while busy are ignored
        for (int i = 0; i < 3; i++) wr(0, i, 9'($urandom));
        run_seq(0, 3, 20, 40, 0, -1, 0, 1'b1, 2000, nls, nsd, ecyc);
        chk("t5_starts", nls, 3);
        chk("t5_seq_done_count", nsd, 1);
        run_seq(0, 3, 3, 25, int'($urandom_range(4, 0)), -1, 0, 1'b0, 2000, nls, nsd, ecyc);
        chk("t5_table_unchanged_rerun", nls, 3);

        // T4: abort in layer 1 WAIT_DONE, then restart from index 0
        run_seq(0, 3, 30, 40, 0, 1, 10, 1'b0, 2000, nls, nsd, ecyc);
        chk("t4_starts_before_abort", nls, 2);
        chk("t4_no_seq_done", nsd, 0);
        chk("t4_error_unchanged", 32'(err_a), 0);
        run_seq(0, 3, 3, 20, 0, -1, 0, 1'b0, 2000, nls, nsd, ecyc);
        chk("t4_restart_starts", nls, 3);
        // abort on the same cycle as done: abort wins, no further layer
        run_seq(0, 3, 5, 15, 0, 0, -1, 1'b0, 2000, nls, nsd, ecyc);
        chk("abort_beats_done_starts", nls, 1);
        chk("abort_beats_done_no_seq_done", nsd, 0);

        // T3: done never arrives -> timeout
        run_seq(0, 3, 100000, 100000, 0, -1, 0, 1'b0, 400, nls, nsd, ecyc);
        chk("t3_error_raised", 32'(ecyc >= 250 && ecyc <= 265), 1);
        chk("t3_one_start", nls, 1);
        chk("t3_no_seq_done", nsd, 0);
        @(negedge clk);
        chk("t3_error_sticky", 32'(err_a), 1);
        run_seq(0, 3, 3, 20, 0, -1, 0, 1'b0, 2000, nls, nsd, ecyc);
        chk("t3_restart_completes", nsd, 1);

        // reset mid-sequence (during layer 1)
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            drv(0, 1'b0, 1'b0, (c >= 8));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_cfg", cfg_a, 0);
        chk("midreset_base", base_a, 0);
        chk("midreset_flags", {26'b0, busy_a, ls_a, li_a}, 0);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ls_a || sd_a) extra++;
        end
        chk("midreset_no_pulses", extra, 0);

        // T6: 16 conv3x3 layers
        for (int i = 0; i < 16; i++) wr(1, i, {3'($urandom), 5'($urandom), 1'b1});
        run_seq(1, 16, 3, 10, 0, -1, 0, 1'b0, 2000, nls, nsd, ecyc);
        chk("t6_starts", nls, 16);
        chk("t6_seq_done_count", nsd, 1);
        chk("t6_last_base", rec_base[15], {12'd240, 20'd2160});

        // randomized tables on the 16-layer instance
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) wr(1, i, 9'($urandom));
            run_seq(1, 16, 3, 12, int'($urandom_range(3, 0)), -1, 0, 1'b0, 3000, nls, nsd, ecyc);
            chk("rand_starts", nls, 16);
            chk("rand_seq_done_count", nsd, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
